// File: rtl/countdown_sequencer.sv
// Countdown timer controller for a chain of BCD decade down-counters.
// Optional macro AUTO_RELOAD_EN: reload the preset at terminal count instead of stopping.
module countdown_sequencer #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  clear,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  paused,
  output logic                  done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  state_t              state;
  logic [PW-1:0]       prescaler;
  logic [4*DIGITS-1:0] clamped;
  logic [4*DIGITS-1:0] decremented;
  logic                borrow;
  logic [4*DIGITS-1:0] step_count;
  logic [PW-1:0]       step_prescaler;
  state_t              step_state;
  logic                step_done;

  assign running = (state == ST_RUN);
  assign paused  = (state == ST_PAUSE);

  always_comb begin
    clamped = load_value;
    for (int d = 0; d < DIGITS; d++) begin
      if (load_value[4*d +: 4] > 4'd9) clamped[4*d +: 4] = 4'd9;
    end
  end

  // Borrow ripples from digit 0 upward; a digit at 0 wraps to 9 and passes the borrow on.
  always_comb begin
    decremented = count;
    borrow      = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (borrow) begin
        if (count[4*d +: 4] == 4'd0) begin
          decremented[4*d +: 4] = 4'd9;
        end else begin
          decremented[4*d +: 4] = count[4*d +: 4] - 4'd1;
          borrow                = 1'b0;
        end
      end
    end
  end

  // One cycle of running time: used both in RUN and on the edge that resumes from PAUSE.
  always_comb begin
    step_prescaler = prescaler + 1'b1;
    step_count     = count;
    step_state     = ST_RUN;
    step_done      = 1'b0;
    if (prescaler == LAST) begin
      step_prescaler = '0;
      step_count     = decremented;
      if (decremented == '0) begin
`ifdef AUTO_RELOAD_EN
        if (clamped != '0) begin
          step_count = clamped;
          step_done  = 1'b1;
        end else begin
          step_state = ST_DONE;
          step_done  = 1'b1;
        end
`else
        step_state = ST_DONE;
        step_done  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      prescaler <= '0;
      done      <= 1'b0;
    end else if (clear) begin
      state     <= ST_IDLE;
      count     <= '0;
      prescaler <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            count     <= clamped;
            prescaler <= '0;
            if (clamped == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              done  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (pause && !start) begin
            state <= ST_PAUSE;
            done  <= 1'b0;
          end else begin
            state     <= step_state;
            count     <= step_count;
            prescaler <= step_prescaler;
            done      <= step_done;
          end
        end
        ST_PAUSE: begin
          if (start || pause) begin
            state     <= step_state;
            count     <= step_count;
            prescaler <= step_prescaler;
            done      <= step_done;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Self-checking bench for countdown_sequencer (DIGITS=2, TICK_DIV=4) with an integer-level reference model.
module tb_countdown_sequencer;

  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;
  localparam int W        = 4 * DIGITS;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSE  = 2;
  localparam int M_DONE   = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] count;
  logic         running;
  logic         paused;
  logic         done;

  int total = 0;
  int bad   = 0;

  int m_val   = 0;
  int m_phase = 0;
  int m_mode  = M_IDLE;
  int m_done  = 0;

  countdown_sequencer #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .clock(clock), .reset(reset), .start(start), .pause(pause), .clear(clear),
    .load_value(load_value), .count(count), .running(running), .paused(paused), .done(done)
  );

  always #5 clock = ~clock;

  function automatic int clamp_val(input logic [W-1:0] v);
    int s, p, dig;
    s = 0;
    p = 1;
    for (int d = 0; d < DIGITS; d++) begin
      dig = int'(v[4*d +: 4]);
      if (dig > 9) dig = 9;
      s += dig * p;
      p *= 10;
    end
    return s;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] b;
    int t;
    b = '0;
    t = v;
    for (int d = 0; d < DIGITS; d++) begin
      b[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  // One cycle of elapsed running time in the timer's own terms.
  task automatic model_run(input logic [W-1:0] lv);
    int r;
    m_mode = M_RUN;
    m_done = 0;
    m_phase++;
    if (m_phase == TICK_DIV) begin
      m_phase = 0;
      m_val--;
      if (m_val == 0) begin
`ifdef AUTO_RELOAD_EN
        r = clamp_val(lv);
        if (r != 0) m_val = r;
        else m_mode = M_DONE;
        m_done = 1;
`else
        m_mode = M_DONE;
        m_done = 1;
`endif
      end
    end
  endtask

  task automatic model_step(input logic st, input logic pa, input logic cl, input logic [W-1:0] lv);
    int r;
    if (cl) begin
      m_val = 0; m_phase = 0; m_mode = M_IDLE; m_done = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE: begin
          if (st) begin
            r = clamp_val(lv);
            m_val = r;
            m_phase = 0;
            m_mode = (r == 0) ? M_DONE : M_RUN;
            m_done = (r == 0) ? 1 : 0;
          end
        end
        M_RUN: begin
          if (pa && !st) begin
            m_mode = M_PAUSE;
            m_done = 0;
          end else begin
            model_run(lv);
          end
        end
        default: begin
          if (st || pa) model_run(lv);
        end
      endcase
    end
  endtask

  task automatic applyStimulus(input logic st, input logic pa, input logic cl);
    start = st; pause = pa; clear = cl;
    @(posedge clock);
    #1;
    model_step(st, pa, cl, load_value);
    start = 1'b0; pause = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    total++;
    if (count !== '0 || running !== 1'b0 || paused !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_initial: count=%h run=%b pau=%b done=%b expected 00 0 0 0", count, running, paused, done);
    end
    reset = 1'b0;
    load_value = 8'h35;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    total++;
    if (count !== 8'h35 || running !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_preload: count=%h run=%b expected 35 1", count, running);
    end
    #3;
    reset = 1'b1;
    #1;
    m_val = 0; m_phase = 0; m_mode = M_IDLE; m_done = 0;
    total++;
    if (count !== '0 || running !== 1'b0 || done !== 1'b0 || paused !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_async: count=%h run=%b done=%b expected 00 0 0", count, running, done);
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_countdown;
    logic [W-1:0] want;
    load_value = 8'h12;
    applyStimulus(1'b1, 1'b0, 1'b0);
    total++;
    if (count !== 8'h12 || running !== 1'b1) begin
      bad++;
      $display("[TB] FAIL count_load: count=%h run=%b expected 12 1", count, running);
    end
    for (int e = 2; e <= 49; e++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      want = 'x;
      case (e)
        5:  want = 8'h11;
        9:  want = 8'h10;
        13: want = 8'h09;
        49: want = 8'h00;
        default: ;
      endcase
      if (e == 5 || e == 9 || e == 13 || e == 49) begin
        total++;
        if (count !== want) begin
          bad++;
          $display("[TB] FAIL count_edge%0d: count=%h expected %h", e, count, want);
        end
      end
      total++;
      if (count !== to_bcd(m_val) || running !== (m_mode == M_RUN) || done !== (m_done != 0)) begin
        bad++;
        $display("[TB] FAIL count_model_e%0d: count=%h run=%b done=%b expected %h %b %b",
                 e, count, running, done, to_bcd(m_val), m_mode == M_RUN, m_done != 0);
      end
    end
    total++;
    if (done !== 1'b1 || running !== 1'b0) begin
      bad++;
      $display("[TB] FAIL count_terminal: done=%b run=%b expected 1 0", done, running);
    end
  endtask

  task automatic test_pause;
    applyStimulus(1'b0, 1'b0, 1'b1);
    load_value = 8'h05;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int e = 2; e <= 6; e++) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (paused !== 1'b1 || running !== 1'b0 || count !== 8'h04) begin
        bad++;
        $display("[TB] FAIL pause_hold_%0d: pau=%b run=%b count=%h expected 1 0 04", i, paused, running, count);
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    total++;
    if (running !== 1'b1 || paused !== 1'b0 || count !== 8'h04) begin
      bad++;
      $display("[TB] FAIL pause_resume: run=%b pau=%b count=%h expected 1 0 04", running, paused, count);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    total++;
    if (count !== 8'h04) begin
      bad++;
      $display("[TB] FAIL pause_resume_plus1: count=%h expected 04", count);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    total++;
    if (count !== 8'h03) begin
      bad++;
      $display("[TB] FAIL pause_resume_plus2: count=%h expected 03", count);
    end
  endtask

  task automatic test_clamp_and_zero;
    applyStimulus(1'b0, 1'b0, 1'b1);
    load_value = 8'h3C;
    applyStimulus(1'b1, 1'b0, 1'b0);
    total++;
    if (count !== 8'h39 || running !== 1'b1) begin
      bad++;
      $display("[TB] FAIL clamp_load: count=%h run=%b expected 39 1", count, running);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    load_value = 8'h00;
    applyStimulus(1'b1, 1'b0, 1'b0);
    total++;
    if (done !== 1'b1 || running !== 1'b0 || count !== 8'h00) begin
      bad++;
      $display("[TB] FAIL zero_load: done=%b run=%b count=%h expected 1 0 00", done, running, count);
    end
  endtask

  task automatic test_priority;
    applyStimulus(1'b0, 1'b0, 1'b1);
    load_value = 8'h07;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    total++;
    if (count !== 8'h00 || running !== 1'b0 || paused !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL prio_clear: count=%h run=%b pau=%b done=%b expected 00 0 0 0", count, running, paused, done);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int e = 2; e <= 5; e++) applyStimulus(1'b0, 1'b0, 1'b0);
    load_value = 8'h99;
    applyStimulus(1'b1, 1'b0, 1'b0);
    total++;
    if (count !== 8'h06 || running !== 1'b1) begin
      bad++;
      $display("[TB] FAIL prio_no_reload: count=%h run=%b expected 06 1", count, running);
    end
  endtask

`ifdef AUTO_RELOAD_EN
  task automatic test_auto_reload;
    logic [W-1:0] want;
    logic         want_done;
    applyStimulus(1'b0, 1'b0, 1'b1);
    load_value = 8'h02;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int e = 2; e <= 40; e++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      want      = (((e - 1) / TICK_DIV) % 2 == 0) ? 8'h02 : 8'h01;
      want_done = ((e - 1) % (2 * TICK_DIV) == 0);
      total++;
      if (count !== want || done !== want_done || running !== 1'b1) begin
        bad++;
        $display("[TB] FAIL auto_e%0d: count=%h done=%b run=%b expected %h %b 1", e, count, done, running, want, want_done);
      end
    end
  endtask
`endif

  task automatic test_random;
    int r;
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) load_value = W'($urandom);
      r = $urandom_range(0, 99);
      if (r < 3)       applyStimulus(1'b0, 1'b0, 1'b1);
      else if (r < 12) applyStimulus(1'b1, 1'b0, 1'b0);
      else if (r < 18) applyStimulus(1'b0, 1'b1, 1'b0);
      else             applyStimulus(1'b0, 1'b0, 1'b0);
      total++;
      if (count !== to_bcd(m_val) || running !== (m_mode == M_RUN) ||
          paused !== (m_mode == M_PAUSE) || done !== (m_done != 0)) begin
        bad++;
        $display("[TB] FAIL random_%0d: count=%h run=%b pau=%b done=%b expected %h %b %b %b",
                 i, count, running, paused, done, to_bcd(m_val), m_mode == M_RUN,
                 m_mode == M_PAUSE, m_done != 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_clamp_and_zero();
    test_priority();
`ifdef AUTO_RELOAD_EN
    test_auto_reload();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
